// File: rtl/div_sign_fixup_if.sv
// Handshake bundle for div_sign_fixup: tag push channel, divider result channel
// and the signed result output channel.
interface div_sign_fixup_if #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 8
);
    logic                      tag_valid_i;
    logic                      tag_ready_o;
    logic                      tag_dividend_neg_i;
    logic                      tag_divisor_neg_i;
    logic                      tag_div_zero_i;

    logic                      res_valid_i;
    logic                      res_ready_o;
    logic [DIVIDEND_WIDTH-1:0] res_quotient_i;
    logic [DIVISOR_WIDTH-1:0]  res_reminder_i;

    logic                      valid_o;
    logic                      ready_i;
    logic [DIVIDEND_WIDTH-1:0] quotient_o;
    logic [DIVISOR_WIDTH-1:0]  reminder_o;
    logic                      div_zero_o;
    logic                      overflow_o;

    // The fixup block itself.
    modport slave (
        input  tag_valid_i, tag_dividend_neg_i, tag_divisor_neg_i, tag_div_zero_i,
        output tag_ready_o,
        input  res_valid_i, res_quotient_i, res_reminder_i,
        output res_ready_o,
        output valid_o, quotient_o, reminder_o, div_zero_o, overflow_o,
        input  ready_i
    );

    // Whoever feeds tags/results and consumes the signed output.
    modport master (
        output tag_valid_i, tag_dividend_neg_i, tag_divisor_neg_i, tag_div_zero_i,
        input  tag_ready_o,
        output res_valid_i, res_quotient_i, res_reminder_i,
        input  res_ready_o,
        input  valid_o, quotient_o, reminder_o, div_zero_o, overflow_o,
        output ready_i
    );
endinterface

// File: rtl/div_sign_fixup.sv
// Restores C-style signed quotient/remainder from unsigned divider magnitudes using an in-order tag FIFO.
// Define DIV_SIGN_FIXUP_SATURATE_EN to saturate an overflowing quotient instead of wrapping it.
module div_sign_fixup #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int TAG_DEPTH      = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    div_sign_fixup_if.slave bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]          PTR_ONE  = PTR_W'(1);
    localparam logic [DIVIDEND_WIDTH-1:0] Q_ONE    = DIVIDEND_WIDTH'(1);
    localparam logic [DIVISOR_WIDTH-1:0]  R_ONE    = DIVISOR_WIDTH'(1);
    localparam logic [DIVIDEND_WIDTH-1:0] Q_MIN    = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};
`ifdef DIV_SIGN_FIXUP_SATURATE_EN
    localparam logic [DIVIDEND_WIDTH-1:0] Q_MAX    = ~Q_MIN;
`endif

    typedef struct packed {
        logic dividend_neg;
        logic divisor_neg;
        logic div_zero;
    } tag_t;

    tag_t                      tag_mem [TAG_DEPTH];
    tag_t                      head;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic                      tag_ready;
    logic                      res_ready;
    logic                      push;
    logic                      pop;

    logic                      neg_q;
    logic                      neg_r;
    logic                      quotient_ovf;
    logic [DIVIDEND_WIDTH-1:0] quotient_d;
    logic [DIVISOR_WIDTH-1:0]  reminder_d;
    logic                      div_zero_d;
    logic                      overflow_d;

    logic                      valid_q;
    logic [DIVIDEND_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  reminder_q;
    logic                      div_zero_q;
    logic                      overflow_q;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign tag_ready = (count < CNT_FULL);
    assign res_ready = (count != '0) && (!valid_q || bus.ready_i);
    assign push      = bus.tag_valid_i && tag_ready;
    assign pop       = bus.res_valid_i && res_ready;
    assign head      = tag_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= {bus.tag_dividend_neg_i, bus.tag_divisor_neg_i, bus.tag_div_zero_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Negating a zero remainder yields zero, so no special case is needed for it.
    always_comb begin
        neg_q        = head.dividend_neg ^ head.divisor_neg;
        neg_r        = head.dividend_neg;
        quotient_ovf = !neg_q && (bus.res_quotient_i == Q_MIN);
        quotient_d   = neg_q ? (~bus.res_quotient_i + Q_ONE) : bus.res_quotient_i;
        reminder_d   = neg_r ? (~bus.res_reminder_i + R_ONE) : bus.res_reminder_i;
        div_zero_d   = 1'b0;
        overflow_d   = 1'b0;
        if (head.div_zero) begin
            quotient_d = '1;
            reminder_d = '0;
            div_zero_d = 1'b1;
        end else if (quotient_ovf) begin
            overflow_d = 1'b1;
`ifdef DIV_SIGN_FIXUP_SATURATE_EN
            quotient_d = Q_MAX;
`else
            quotient_d = bus.res_quotient_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            quotient_q <= '0;
            reminder_q <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (pop) begin
            valid_q    <= 1'b1;
            quotient_q <= quotient_d;
            reminder_q <= reminder_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end else if (bus.ready_i) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.tag_ready_o = tag_ready;
    assign bus.res_ready_o = res_ready;
    assign bus.valid_o     = valid_q;
    assign bus.quotient_o  = quotient_q;
    assign bus.reminder_o  = reminder_q;
    assign bus.div_zero_o  = div_zero_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_div_sign_fixup.sv
// Self-checking bench for div_sign_fixup; expected results come from signed integer division of the
// original operands. Honours DIV_SIGN_FIXUP_SATURATE_EN when defined.
module tb_div_sign_fixup;
    localparam int DEPTH = 16;

    typedef struct {
        int a;
        int b;
    } op_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    div_sign_fixup_if #(.DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(8)) bus ();

    div_sign_fixup #(
        .DIVIDEND_WIDTH(8),
        .DIVISOR_WIDTH (8),
        .TAG_DEPTH     (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // C semantics: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   qi;
        int   ri;
        if (b == 0) begin
            e.q = 8'hFF; e.r = 8'h00; e.dz = 1'b1; e.ov = 1'b0;
        end else begin
            qi   = a / b;
            ri   = a % b;
            e.dz = 1'b0;
            e.ov = (qi > 127);
            e.q  = 8'(qi);
            e.r  = 8'(ri);
`ifdef DIV_SIGN_FIXUP_SATURATE_EN
            if (e.ov) e.q = 8'h7F;
`endif
        end
        return e;
    endfunction

    function automatic logic [7:0] mag_q(input int a, input int b);
        int ua = (a < 0) ? -a : a;
        int ub = (b < 0) ? -b : b;
        if (b == 0) return 8'hFF;
        return 8'(ua / ub);
    endfunction

    function automatic logic [7:0] mag_r(input int a, input int b);
        int ua = (a < 0) ? -a : a;
        int ub = (b < 0) ? -b : b;
        if (b == 0) return 8'h2A;
        return 8'(ua % ub);
    endfunction

    function automatic logic [18:0] pack_exp(input exp_t e);
        return {1'b1, e.q, e.r, e.dz, e.ov};
    endfunction

    function automatic logic [18:0] out_vec();
        return {bus.valid_o, bus.quotient_o, bus.reminder_o, bus.div_zero_o, bus.overflow_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.tag_valid_i        = 1'b0;
        bus.tag_dividend_neg_i = 1'b0;
        bus.tag_divisor_neg_i  = 1'b0;
        bus.tag_div_zero_i     = 1'b0;
        bus.res_valid_i        = 1'b0;
        bus.res_quotient_i     = 8'h00;
        bus.res_reminder_i     = 8'h00;
        bus.ready_i            = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_tag(input int a, input int b);
        bus.tag_dividend_neg_i = (a < 0);
        bus.tag_divisor_neg_i  = (b < 0);
        bus.tag_div_zero_i     = (b == 0);
    endtask

    task automatic set_result(input int a, input int b);
        bus.res_quotient_i = mag_q(a, b);
        bus.res_reminder_i = mag_r(a, b);
    endtask

    task automatic push_tag(input int a, input int b);
        int n = 0;
        set_tag(a, b);
        bus.tag_valid_i = 1'b1;
        while (!bus.tag_ready_o && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n == 50) begin
            bad++;
            $display("[TB] FAIL push_timeout: tag_ready_o=%b required 1", bus.tag_ready_o);
        end
        tick();
        bus.tag_valid_i = 1'b0;
    endtask

    task automatic send_result(input int a, input int b);
        int n = 0;
        set_result(a, b);
        bus.res_valid_i = 1'b1;
        while (!bus.res_ready_o && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n == 50) begin
            bad++;
            $display("[TB] FAIL result_timeout: res_ready_o=%b required 1", bus.res_ready_o);
        end
        tick();
        bus.res_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.res_valid_i = 1'b1;
        bus.ready_i     = 1'b1;
        #1;
        total++;
        if (out_vec() !== 19'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h required %h", out_vec(), 19'h0);
        end
        total++;
        if (bus.tag_ready_o !== 1'b1 || bus.res_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready: got tag=%b res=%b required tag=1 res=0",
                     bus.tag_ready_o, bus.res_ready_o);
        end
        clear_inputs();
    endtask

    task automatic test_directed();
        int a_list [7] = '{-17, -128, 42, 17, -20, 7, -128};
        int b_list [7] = '{5, -1, 0, -5, 5, 9, 1};
        apply_reset();
        bus.ready_i = 1'b1;
        foreach (a_list[i]) begin
            push_tag(a_list[i], b_list[i]);
            send_result(a_list[i], b_list[i]);
            total++;
            if (out_vec() !== pack_exp(model(a_list[i], b_list[i]))) begin
                bad++;
                $display("[TB] FAIL directed_%0d_div_%0d: got %h required %h", a_list[i], b_list[i],
                         out_vec(), pack_exp(model(a_list[i], b_list[i])));
            end
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL directed_valid_clear: got %b required 0", bus.valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] first;
        apply_reset();
        push_tag(-17, 5);
        push_tag(17, -5);
        send_result(-17, 5);
        first = pack_exp(model(-17, 5));
        set_result(17, -5);
        bus.res_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_vec() !== first || bus.res_ready_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold_%0d: got out=%h res_ready=%b required out=%h res_ready=0",
                         i, out_vec(), bus.res_ready_o, first);
            end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        total++;
        if (bus.res_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_release_ready: got %b required 1", bus.res_ready_o);
        end
        tick();
        bus.res_valid_i = 1'b0;
        total++;
        if (out_vec() !== pack_exp(model(17, -5))) begin
            bad++;
            $display("[TB] FAIL back_to_back_second: got %h required %h", out_vec(),
                     pack_exp(model(17, -5)));
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL back_to_back_drain: got %b required 0", bus.valid_o);
        end
    endtask

    task automatic test_empty_stall();
        apply_reset();
        bus.ready_i = 1'b1;
        set_result(5, 1);
        bus.res_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.res_ready_o !== 1'b0 || bus.valid_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL empty_stall_%0d: got res_ready=%b valid=%b required 0 0",
                         i, bus.res_ready_o, bus.valid_o);
            end
            tick();
        end
        set_tag(5, 1);
        bus.tag_valid_i = 1'b1;
        #1;
        total++;
        if (bus.res_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_bypass: got res_ready=%b required 0", bus.res_ready_o);
        end
        tick();
        bus.tag_valid_i = 1'b0;
        #1;
        total++;
        if (bus.res_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stalled_accept: got res_ready=%b required 1", bus.res_ready_o);
        end
        tick();
        bus.res_valid_i = 1'b0;
        total++;
        if (out_vec() !== pack_exp(model(5, 1))) begin
            bad++;
            $display("[TB] FAIL stalled_result: got %h required %h", out_vec(), pack_exp(model(5, 1)));
        end
    endtask

    task automatic test_fifo_full();
        op_t q[$];
        op_t o;
        apply_reset();
        bus.ready_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            push_tag(-i, 1);
            o.a = -i; o.b = 1;
            q.push_back(o);
        end
        total++;
        if (bus.tag_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ready: got %b required 0", bus.tag_ready_o);
        end
        set_tag(99, 1);
        bus.tag_valid_i = 1'b1;
        set_result(q[0].a, q[0].b);
        bus.res_valid_i = 1'b1;
        #1;
        total++;
        if (bus.tag_ready_o !== 1'b0 || bus.res_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_pop_push: got tag=%b res=%b required tag=0 res=1",
                     bus.tag_ready_o, bus.res_ready_o);
        end
        tick();
        bus.tag_valid_i = 1'b0;
        bus.res_valid_i = 1'b0;
        total++;
        if (bus.tag_ready_o !== 1'b1 || out_vec() !== pack_exp(model(q[0].a, q[0].b))) begin
            bad++;
            $display("[TB] FAIL full_after_pop: got tag=%b out=%h required tag=1 out=%h",
                     bus.tag_ready_o, out_vec(), pack_exp(model(q[0].a, q[0].b)));
        end
        void'(q.pop_front());
        push_tag(100, 1);
        o.a = 100; o.b = 1;
        q.push_back(o);
        total++;
        if (bus.tag_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL refill_ready: got %b required 0", bus.tag_ready_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_result(q[0].a, q[0].b);
            bus.res_valid_i = 1'b1;
            tick();
            total++;
            if (out_vec() !== pack_exp(model(q[0].a, q[0].b))) begin
                bad++;
                $display("[TB] FAIL drain_%0d: got %h required %h", i, out_vec(),
                         pack_exp(model(q[0].a, q[0].b)));
            end
            void'(q.pop_front());
        end
        bus.res_valid_i = 1'b0;
        #1;
        total++;
        if (bus.res_ready_o !== 1'b0 || bus.tag_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drained_empty: got res=%b tag=%b required res=0 tag=1",
                     bus.res_ready_o, bus.tag_ready_o);
        end
    endtask

    task automatic test_random();
        op_t   infl[$];
        exp_t  outq[$];
        op_t   cur;
        int    issued = 0;
        int    cycles = 0;
        bit    exp_rr;
        bit    do_push;
        bit    do_pop;
        bit    consume;
        int    sel;
        apply_reset();
        while ((issued < 200 || infl.size() != 0 || outq.size() != 0) && cycles < 5000) begin
            bus.tag_valid_i = 1'b0;
            if (issued < 200 && $urandom_range(0, 3) != 0) begin
                cur.a = int'($urandom_range(0, 255)) - 128;
                sel   = int'($urandom_range(0, 9));
                if (sel == 0) cur.b = 0;
                else if (sel == 1) begin cur.a = -128; cur.b = -1; end
                else cur.b = int'($urandom_range(0, 255)) - 128;
                set_tag(cur.a, cur.b);
                bus.tag_valid_i = 1'b1;
            end
            bus.res_valid_i = 1'b0;
            if (infl.size() != 0 && $urandom_range(0, 3) != 0) begin
                set_result(infl[0].a, infl[0].b);
                if (infl[0].b == 0) bus.res_quotient_i = 8'($urandom);
                bus.res_valid_i = 1'b1;
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_rr = (infl.size() != 0) && (outq.size() == 0 || bus.ready_i);
            total++;
            if (bus.res_ready_o !== exp_rr || bus.tag_ready_o !== (infl.size() < DEPTH)) begin
                bad++;
                $display("[TB] FAIL rand_ready c%0d: got res=%b tag=%b required res=%b tag=%b", cycles,
                         bus.res_ready_o, bus.tag_ready_o, exp_rr, (infl.size() < DEPTH));
            end
            total++;
            if (outq.size() == 0 ? (bus.valid_o !== 1'b0) : (out_vec() !== pack_exp(outq[0]))) begin
                bad++;
                $display("[TB] FAIL rand_out c%0d: got %h required %h", cycles, out_vec(),
                         (outq.size() == 0) ? 19'h0 : pack_exp(outq[0]));
            end
            do_push = bus.tag_valid_i && (infl.size() < DEPTH);
            do_pop  = bus.res_valid_i && exp_rr;
            consume = (outq.size() != 0) && bus.ready_i;
            tick();
            cycles++;
            if (consume) void'(outq.pop_front());
            if (do_pop) begin
                outq.push_back(model(infl[0].a, infl[0].b));
                void'(infl.pop_front());
            end
            if (do_push) begin
                infl.push_back(cur);
                issued++;
            end
        end
        total++;
        if (cycles >= 5000) begin
            bad++;
            $display("[TB] FAIL rand_timeout: issued=%0d required 200", issued);
        end
        clear_inputs();
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 4; i++) push_tag(-9 - i, 2);
        send_result(-9, 2);
        total++;
        if (bus.valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midstream_setup: got valid=%b required 1", bus.valid_o);
        end
        set_result(-10, 2);
        bus.res_valid_i = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        total++;
        if (out_vec() !== 19'h0 || bus.tag_ready_o !== 1'b1 || bus.res_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midstream_reset: got out=%h tag=%b res=%b required out=0 tag=1 res=0",
                     out_vec(), bus.tag_ready_o, bus.res_ready_o);
        end
        tick();
        total++;
        if (bus.res_ready_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midstream_flushed: got res=%b valid=%b required 0 0",
                     bus.res_ready_o, bus.valid_o);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_directed();
        test_backpressure();
        test_empty_stall();
        test_fifo_full();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
